// File: rtl/tu_sm_decoder.sv
// Temporal-unary sign-magnitude decoder: counts '1' beats over a framed window
// and presents the signed two's-complement result in a 1-entry output register.
module tu_sm_decoder #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             i_valid,
   input  logic             i_start,
   input  logic             i_last,
   input  logic             i_sign,
   input  logic             i_bit,
   output logic             o_valid,
   input  logic             o_ready,
   output logic [WIDTH-1:0] o_data,
   output logic             o_ovf,
   output logic             o_busy
);

   typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

   localparam logic [WIDTH-2:0] CNT_MAX = '1;

   state_t           state_q, state_d;
   logic [WIDTH-2:0] cnt_q, cnt_d;
   logic             sign_q, sign_d;
   logic             done;
   logic [WIDTH-1:0] result;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sign_d  = sign_q;
      done    = 1'b0;
      if (i_valid) begin
         if (i_start) begin
            // A start beat always opens a fresh window, discarding any partial count.
            cnt_d    = '0;
            cnt_d[0] = i_bit;
            sign_d   = i_sign;
            if (i_last) begin
               done    = 1'b1;
               state_d = IDLE;
            end else begin
               state_d = ACC;
            end
         end else if (state_q == ACC) begin
            if (i_bit && (cnt_q != CNT_MAX)) begin
               cnt_d = cnt_q + 1'b1;
            end
            if (i_last) begin
               done    = 1'b1;
               state_d = IDLE;
            end
         end
      end
   end

   assign result = sign_d ? -{1'b0, cnt_d} : {1'b0, cnt_d};
   assign o_busy = (state_q == ACC);

   // Output handshake: o_valid/o_data hold until o_valid & o_ready; a completion
   // in the same cycle replaces the word, and one while o_valid & ~o_ready
   // overwrites it and sets the sticky o_ovf.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sign_q  <= 1'b0;
         o_valid <= 1'b0;
         o_data  <= '0;
         o_ovf   <= 1'b0;
      end else if (clr) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sign_q  <= 1'b0;
         o_valid <= 1'b0;
         o_data  <= '0;
         o_ovf   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sign_q  <= sign_d;
         if (done) begin
            o_data  <= result;
            o_valid <= 1'b1;
            if (o_valid && !o_ready) begin
               o_ovf <= 1'b1;
            end
         end else if (o_valid && o_ready) begin
            o_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_tu_sm_decoder.sv
// Bench for tu_sm_decoder (WIDTH=8): directed windows feed an expected-word
// queue; a negedge monitor pops and compares every accepted output word.
module tb_tu_sm_decoder;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             clr = 1'b0;
   logic             i_valid = 1'b0;
   logic             i_start = 1'b0;
   logic             i_last = 1'b0;
   logic             i_sign = 1'b0;
   logic             i_bit = 1'b0;
   logic             o_valid;
   logic             o_ready = 1'b0;
   logic [WIDTH-1:0] o_data;
   logic             o_ovf;
   logic             o_busy;

   logic [WIDTH-1:0] exp_q[$];
   int               n_vec = 0;
   int               n_err = 0;

   tu_sm_decoder #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst), .clr(clr),
      .i_valid(i_valid), .i_start(i_start), .i_last(i_last),
      .i_sign(i_sign), .i_bit(i_bit),
      .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
      .o_ovf(o_ovf), .o_busy(o_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every accepted word must match the head of the expected queue.
   always @(negedge clk) begin
      if (!rst && o_valid && o_ready) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_word: got %0h, expected none", o_data);
         end else begin
            logic [WIDTH-1:0] e;
            e = exp_q.pop_front();
            if (o_data !== e) begin
               n_err++;
               $display("FAIL o_data: got %0h, expected %0h", o_data, e);
            end
         end
      end
   end

   task automatic beat(input logic st, input logic la, input logic sg, input logic b);
      i_valid = 1'b1;
      i_start = st;
      i_last  = la;
      i_sign  = sg;
      i_bit   = b;
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      i_start = 1'b0;
      i_last  = 1'b0;
      i_sign  = 1'b0;
      i_bit   = 1'b0;
   endtask

   // Window of n beats; the first 'ones' beats carry i_bit=1.
   task automatic window(input logic sg, input int n, input int ones);
      for (int i = 0; i < n; i++) begin
         beat(i == 0, i == n - 1, (i == 0) ? sg : ~sg, i < ones);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_o_valid"}, o_valid, 0);
      check({tag, "_o_data"}, o_data, 0);
      check({tag, "_o_ovf"}, o_ovf, 0);
      check({tag, "_o_busy"}, o_busy, 0);
   endtask

   initial begin
      #1;
      check_all_zero("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;

      // 1: positive window, single-cycle o_valid with o_ready high
      o_ready = 1'b1;
      exp_q.push_back(8'd5);
      window(1'b0, 9, 5);
      check("t1_valid_set", o_valid, 1);
      @(posedge clk);
      #1;
      check("t1_valid_drop", o_valid, 0);

      // 2: negative window and signed zero
      exp_q.push_back(8'hFB);
      window(1'b1, 9, 5);
      exp_q.push_back(8'h00);
      window(1'b1, 6, 0);

      // 3: saturation at 127
      exp_q.push_back(8'h81);
      window(1'b1, 200, 200);

      // 4: overwrite while stalled
      repeat (2) @(posedge clk);
      #1;
      o_ready = 1'b0;
      window(1'b0, 5, 3);
      check("t4_ovf_before", o_ovf, 0);
      window(1'b0, 9, 7);
      check("t4_data", o_data, 8'd7);
      check("t4_ovf", o_ovf, 1);
      check("t4_valid_held", o_valid, 1);
      exp_q.push_back(8'd7);
      o_ready = 1'b1;
      @(posedge clk);
      #1;
      check("t4_valid_drop", o_valid, 0);
      check("t4_ovf_sticky", o_ovf, 1);

      // 5: restart mid-window, then 1-beat window back to back
      exp_q.push_back(8'hFE);
      exp_q.push_back(8'd1);
      beat(1'b1, 1'b0, 1'b0, 1'b1);
      repeat (3) beat(1'b0, 1'b0, 1'b0, 1'b1);
      check("t5_busy", o_busy, 1);
      beat(1'b1, 1'b0, 1'b1, 1'b1);
      beat(1'b0, 1'b0, 1'b0, 1'b1);
      beat(1'b0, 1'b1, 1'b0, 1'b0);
      check("t5_idle", o_busy, 0);
      beat(1'b1, 1'b1, 1'b0, 1'b1);
      @(posedge clk);
      #1;

      // 6a: async reset mid-window with a held result
      o_ready = 1'b0;
      window(1'b0, 1, 1);
      beat(1'b1, 1'b0, 1'b0, 1'b1);
      repeat (5) beat(1'b0, 1'b0, 1'b0, 1'b1);
      check("t6_pre_valid", o_valid, 1);
      #2;
      rst = 1'b1;
      #1;
      check_all_zero("t6_rst");
      #2;
      rst = 1'b0;
      o_ready = 1'b1;
      exp_q.push_back(8'd3);
      window(1'b0, 4, 3);
      @(posedge clk);
      #1;

      // 6b: same with synchronous clear, overflow set beforehand
      o_ready = 1'b0;
      window(1'b0, 1, 1);
      window(1'b0, 2, 1);
      check("t6_pre_ovf", o_ovf, 1);
      beat(1'b1, 1'b0, 1'b0, 1'b1);
      repeat (5) beat(1'b0, 1'b0, 1'b0, 1'b1);
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
      check_all_zero("t6_clr");
      o_ready = 1'b1;
      exp_q.push_back(8'd3);
      window(1'b0, 4, 3);

      // Drain: every expected word must have been accepted in bounded time.
      for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(posedge clk);
      repeat (2) @(posedge clk);
      check("queue_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
